debounce_tick: RTL and testbench

DEBOUNCE_TICK -- requirements
Module: debounce_tick

---
 rtl/debounce_tick.sv | 119 +++++++++++
 tb/tb_debounce_tick.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_tick.sv
// Per-channel push-button debouncer paced by a 500 Hz tick derived from clock500.
// Each channel qualifies a level change only after STABLE_TICKS consecutive ticks.
module debounce_tick #(
    parameter int N_BTN        = 4,
    parameter int STABLE_TICKS = 10
) (
    input  logic             clock50,
    input  logic             reset,
    input  logic             clock500,
    input  logic [N_BTN-1:0] key_n,
    output logic             tick,
    output logic [N_BTN-1:0] pressed,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    localparam logic [7:0] LAST = 8'(STABLE_TICKS - 1);

    logic             s1, s2, s3;
    logic [N_BTN-1:0] key_p0, key_p1;
    logic [N_BTN-1:0] lvl;
    state_t           state [N_BTN];
    logic [7:0]       cnt   [N_BTN];

    assign lvl = ~key_p1;

    // clock500 is sampled as data; tick marks its rising edge
    always_ff @(posedge clock50) begin
        if (reset) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            s3     <= 1'b0;
            tick   <= 1'b0;
            key_p0 <= '1;
            key_p1 <= '1;
        end else begin
            s1     <= clock500;
            s2     <= s1;
            s3     <= s2;
            tick   <= s2 & ~s3;
            key_p0 <= key_n;
            key_p1 <= key_p0;
        end
    end

    always_ff @(posedge clock50) begin
        if (reset) begin
            for (int i = 0; i < N_BTN; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
            end
            pressed       <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
        end else begin
            press_pulse   <= '0;
            release_pulse <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                case (state[i])
                    IDLE: begin
                        if (lvl[i]) begin
                            state[i] <= PRESS_WAIT;
                            cnt[i]   <= '0;
                        end
                    end
                    // a bounce wins over a coincident tick
                    PRESS_WAIT: begin
                        if (!lvl[i]) begin
                            state[i] <= IDLE;
                            cnt[i]   <= '0;
                        end else if (tick) begin
                            if (cnt[i] == LAST) begin
                                state[i]       <= PRESSED;
                                cnt[i]         <= '0;
                                pressed[i]     <= 1'b1;
                                press_pulse[i] <= 1'b1;
                            end else begin
                                cnt[i] <= cnt[i] + 8'd1;
                            end
                        end
                    end
                    PRESSED: begin
                        if (!lvl[i]) begin
                            state[i] <= RELEASE_WAIT;
                            cnt[i]   <= '0;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (lvl[i]) begin
                            state[i] <= PRESSED;
                            cnt[i]   <= '0;
                        end else if (tick) begin
                            if (cnt[i] == LAST) begin
                                state[i]         <= IDLE;
                                cnt[i]           <= '0;
                                pressed[i]       <= 1'b0;
                                release_pulse[i] <= 1'b1;
                            end else begin
                                cnt[i] <= cnt[i] + 8'd1;
                            end
                        end
                    end
                    default: begin
                        state[i] <= IDLE;
                        cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_debounce_tick.sv
// Directed bench for debounce_tick with STABLE_TICKS=3 and a 20-cycle clock500.
// Inputs change and outputs are read 1 ns after the falling edge of clock50.
module tb_debounce_tick;

    localparam int N = 4;

    logic         clock50;
    logic         reset;
    logic         clock500;
    logic [N-1:0] key_n;
    logic         tick;
    logic [N-1:0] pressed, press_pulse, release_pulse;

    int errors = 0;
    int checks = 0;

    int press_cnt [N];
    int rel_cnt   [N];
    int tick_cnt  = 0;
    int rise_cnt  = 0;
    int both_viol = 0;
    int wide_viol = 0;
    int tick_wide = 0;
    logic         prev_tick = 1'b0;
    logic [N-1:0] prev_pp = '0, prev_rp = '0;

    debounce_tick #(.N_BTN(N), .STABLE_TICKS(3)) dut (
        .clock50      (clock50),
        .reset        (reset),
        .clock500     (clock500),
        .key_n        (key_n),
        .tick         (tick),
        .pressed      (pressed),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );

    initial clock50 = 1'b0;
    always #5 clock50 = ~clock50;

    initial begin
        clock500 = 1'b0;
        forever begin
            repeat (10) @(posedge clock50);
            #1 clock500 = ~clock500;
            if (clock500) rise_cnt++;
        end
    end

    always @(negedge clock50) begin
        if (tick) tick_cnt++;
        if (tick && prev_tick) tick_wide++;
        prev_tick = tick;
        for (int i = 0; i < N; i++) begin
            if (press_pulse[i]) press_cnt[i]++;
            if (release_pulse[i]) rel_cnt[i]++;
            if (press_pulse[i] && release_pulse[i]) both_viol++;
            if ((press_pulse[i] && prev_pp[i]) || (release_pulse[i] && prev_rp[i])) wide_viol++;
        end
        prev_pp = press_pulse;
        prev_rp = release_pulse;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clock50);
        #1;
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin
            step();
            n++;
        end while (tick !== 1'b1 && n < 100);
        if (tick !== 1'b1) chk("tick_timeout", 32'(tick), 32'd1);
    endtask

    task automatic wait_ticks(input int k);
        for (int j = 0; j < k; j++) wait_tick();
    endtask

    int rc, pc;

    initial begin
        for (int i = 0; i < N; i++) begin
            press_cnt[i] = 0;
            rel_cnt[i]   = 0;
        end
        reset = 1'b1;
        key_n = '1;
        repeat (3) step();
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_pressed", 32'(pressed), 32'd0);
        chk("rst_press_pulse", 32'(press_pulse), 32'd0);
        chk("rst_release_pulse", 32'(release_pulse), 32'd0);
        reset = 1'b0;

        // single press, accepted on the third tick
        wait_tick();
        key_n[0] = 1'b0;
        wait_ticks(3);
        chk("a_t3_pulse", 32'(press_pulse), 32'd0);
        chk("a_t3_pressed", 32'(pressed), 32'd0);
        step();
        chk("a_pulse", 32'(press_pulse), 32'b0001);
        chk("a_pressed", 32'(pressed), 32'b0001);
        step();
        chk("a_pulse_end", 32'(press_pulse), 32'd0);
        chk("a_pressed_hold", 32'(pressed), 32'b0001);

        // release, then a re-press interrupting RELEASE_WAIT
        wait_tick();
        key_n[0] = 1'b1;
        wait_ticks(3);
        chk("b_t3_pressed", 32'(pressed), 32'b0001);
        chk("b_t3_rel", 32'(release_pulse), 32'd0);
        step();
        chk("b_rel_pulse", 32'(release_pulse), 32'b0001);
        chk("b_rel_pressed", 32'(pressed), 32'd0);
        step();
        chk("b_rel_end", 32'(release_pulse), 32'd0);
        wait_tick();
        key_n[0] = 1'b0;
        wait_ticks(4);
        chk("b_repress", 32'(pressed), 32'b0001);
        rc = rel_cnt[0];
        pc = press_cnt[0];
        wait_tick();
        key_n[0] = 1'b1;
        wait_tick();
        key_n[0] = 1'b0;
        wait_ticks(3);
        chk("b_glitch_pressed", 32'(pressed), 32'b0001);
        chk("b_glitch_rel", 32'(rel_cnt[0]), 32'(rc));
        chk("b_glitch_press", 32'(press_cnt[0]), 32'(pc));
        key_n[0] = 1'b1;
        wait_ticks(5);
        chk("b_final_rel", 32'(rel_cnt[0]), 32'(rc + 1));
        chk("b_final_pressed", 32'(pressed), 32'd0);

        // bouncing key on channel 1
        for (int c = 0; c < 200; c++) begin
            if (c % 7 == 0) key_n[1] = ~key_n[1];
            step();
        end
        chk("c_bounce_press", 32'(press_cnt[1]), 32'd0);
        chk("c_bounce_pressed", 32'(pressed), 32'd0);
        key_n[1] = 1'b0;
        wait_ticks(5);
        chk("c_press", 32'(press_cnt[1]), 32'd1);
        chk("c_pressed", 32'(pressed), 32'b0010);
        key_n[1] = 1'b1;
        wait_ticks(5);
        chk("c_release", 32'(rel_cnt[1]), 32'd1);

        // bounce arriving together with the tick that would accept
        wait_tick();
        key_n[2] = 1'b0;
        wait_ticks(2);
        repeat (18) step();
        key_n[2] = 1'b1;
        step();
        step();
        chk("d_align", 32'(tick), 32'd1);
        step();
        chk("d_no_press", 32'(press_cnt[2]), 32'd0);
        chk("d_pressed", 32'(pressed), 32'd0);
        wait_tick();
        key_n[2] = 1'b0;
        wait_ticks(2);
        chk("d_restart", 32'(press_cnt[2]), 32'd0);
        wait_tick();
        step();
        chk("d_full_press", 32'(press_pulse), 32'b0100);
        key_n[2] = 1'b1;
        wait_ticks(5);

        // reset mid-debounce with cnt=2, clock500 low
        wait_tick();
        key_n[3] = 1'b0;
        wait_ticks(2);
        repeat (10) step();
        reset = 1'b1;
        step();
        chk("e_rst_outputs", 32'({tick, pressed, press_pulse, release_pulse}), 32'd0);
        reset = 1'b0;
        wait_ticks(2);
        chk("e_no_early", 32'(press_cnt[3]), 32'd0);
        wait_tick();
        chk("e_t3_pulse", 32'(press_pulse), 32'd0);
        step();
        chk("e_press", 32'(press_pulse), 32'b1000);
        key_n[3] = 1'b1;
        wait_ticks(5);

        // all four channels at once
        wait_tick();
        key_n = '0;
        wait_ticks(3);
        chk("f_t3_pulse", 32'(press_pulse), 32'd0);
        step();
        chk("f_press_all", 32'(press_pulse), 32'b1111);
        chk("f_pressed_all", 32'(pressed), 32'b1111);
        wait_tick();
        key_n = '1;
        wait_ticks(3);
        step();
        chk("f_rel_all", 32'(release_pulse), 32'b1111);
        chk("f_released", 32'(pressed), 32'd0);

        wait_tick();
        step();
        step();
        chk("tick_vs_edges", 32'(tick_cnt), 32'(rise_cnt));
        chk("tick_width", 32'(tick_wide), 32'd0);
        chk("pulse_overlap", 32'(both_viol), 32'd0);
        chk("pulse_width", 32'(wide_viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
